arbitro_memoria: RTL and testbench

//   Shares CPUCR main memory (16-bit address, 8-bit bidirectional data bus, LE read/write strobe)

---
 rtl/arbitro_memoria.sv | 112 +++++++++++
 tb/tb_arbitro_memoria.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/arbitro_memoria.sv
// Round-robin arbiter sharing CPUCR main memory between the fetch unit (A) and the loader/DMA port (B).
// One transaction at a time: IDLE -> ADDR -> RD_WAIT | WR_STROBE -> ACK -> IDLE.
module arbitro_memoria #(
  parameter int READ_WAIT = 1,
  parameter int WR_PULSE  = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [15:0] a_dir,
  input  logic [7:0]  a_wdata,
  output logic [7:0]  a_rdata,
  output logic        a_ack,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [15:0] b_dir,
  input  logic [7:0]  b_wdata,
  output logic [7:0]  b_rdata,
  output logic        b_ack,
  output logic [15:0] mem_dir,
  output logic        mem_le,
  inout  wire  [7:0]  mem_datos,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [2:0] {IDLE, ADDR, RD_WAIT, WR_STROBE, ACK} state_t;

  typedef struct packed {
    logic        we;
    logic [15:0] dir;
    logic [7:0]  wdata;
  } req_t;

  localparam logic [2:0] RD_LOAD = (READ_WAIT > 0) ? 3'(READ_WAIT - 1) : 3'd0;
  localparam logic [2:0] WR_LOAD = (WR_PULSE  > 0) ? 3'(WR_PULSE  - 1) : 3'd0;

  state_t     state;
  req_t       req_q;
  logic [2:0] cnt;
  logic       ptr;
  logic       gnt;
  logic       rd_done;
  logic       wr_done;

  // Controller drives the bus exactly while LE is low, so reset releases it at once.
  assign mem_datos = mem_le ? 8'bz : req_q.wdata;

  always_comb begin
    gnt     = (a_req && b_req) ? ptr : ~a_req;
    rd_done = !req_q.we && ((state == RD_WAIT && cnt == 3'd0) ||
                            (state == ADDR && READ_WAIT == 0));
    wr_done = (state == WR_STROBE) && (cnt == 3'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      req_q   <= '0;
      cnt     <= '0;
      ptr     <= 1'b0;
      owner   <= 1'b0;
      busy    <= 1'b0;
      mem_le  <= 1'b1;
      mem_dir <= '0;
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state)
        IDLE: if (a_req || b_req) begin
          owner   <= gnt;
          req_q   <= gnt ? {b_we, b_dir, b_wdata} : {a_we, a_dir, a_wdata};
          mem_dir <= gnt ? b_dir : a_dir;
          busy    <= 1'b1;
          state   <= ADDR;
        end
        ADDR: if (req_q.we) begin
          mem_le <= 1'b0;
          cnt    <= WR_LOAD;
          state  <= WR_STROBE;
        end else if (!rd_done) begin
          cnt   <= RD_LOAD;
          state <= RD_WAIT;
        end
        RD_WAIT:   if (!rd_done) cnt <= cnt - 3'd1;
        WR_STROBE: if (!wr_done) cnt <= cnt - 3'd1;
        ACK: begin
          ptr   <= ~owner;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (rd_done || wr_done) begin
        state <= ACK;
        if (owner) b_ack <= 1'b1;
        else       a_ack <= 1'b1;
      end
      if (rd_done) begin
        if (owner) b_rdata <= mem_datos;
        else       a_rdata <= mem_datos;
      end
      if (wr_done) mem_le <= 1'b1;
    end
  end

endmodule

// File: tb/tb_arbitro_memoria.sv
// Directed bench for arbitro_memoria with a behavioural 64K x 8 memory on the shared bus.
module tb_arbitro_memoria;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [15:0] a_dir = '0, b_dir = '0;
  logic [7:0]  a_wdata = '0, b_wdata = '0;
  logic [7:0]  a_rdata, b_rdata;
  logic        a_ack, b_ack, mem_le, busy, owner;
  logic [15:0] mem_dir;
  wire  [7:0]  mem_datos;

  logic [7:0]  mem [0:65535];
  logic        mem_en = 1'b0;
  logic        mon_on = 1'b0;
  int          n_chk = 0, n_pass = 0;

  arbitro_memoria #(.READ_WAIT(1), .WR_PULSE(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_dir(a_dir), .a_wdata(a_wdata), .a_rdata(a_rdata), .a_ack(a_ack),
    .b_req(b_req), .b_we(b_we), .b_dir(b_dir), .b_wdata(b_wdata), .b_rdata(b_rdata), .b_ack(b_ack),
    .mem_dir(mem_dir), .mem_le(mem_le), .mem_datos(mem_datos), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // Memory: drives the bus while LE=1, stores on the falling edge of LE.
  assign mem_datos = (mem_en && mem_le) ? mem[mem_dir] : 8'bz;

  initial forever begin
    @(negedge mem_le);
    #1;
    mem[mem_dir] = mem_datos;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Bus health: never X when something should drive, never driven while LE=1 and memory is off.
  always @(negedge clk) if (mon_on) begin
    if (mem_en || !mem_le) chk("bus_not_x", 32'($isunknown(mem_datos)), 32'd0);
    else                   chk("bus_released", 32'(mem_datos === 8'hzz), 32'd1);
  end

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic txn(input string tag, input bit side, input bit we, input logic [15:0] dir,
                     input logic [7:0] wd, output logic [7:0] rd, output int lat);
    bit got = 0;
    int n = 0;
    if (side) begin b_req = 1; b_we = we; b_dir = dir; b_wdata = wd; end
    else      begin a_req = 1; a_we = we; a_dir = dir; a_wdata = wd; end
    while (!got && n < 20) begin
      @(posedge clk); #1; n++;
      if (side ? b_ack : a_ack) got = 1;
    end
    chk({tag, "_ack_seen"}, 32'(got), 32'd1);
    chk({tag, "_other_ack"}, 32'(side ? a_ack : b_ack), 32'd0);
    rd  = side ? b_rdata : a_rdata;
    lat = n;
    a_req = 0; b_req = 0;
    @(posedge clk); #1;
    chk({tag, "_ack_pulse"}, 32'(side ? b_ack : a_ack), 32'd0);
    chk({tag, "_rdata_held"}, 32'(side ? b_rdata : a_rdata), 32'(rd));
  endtask

  initial begin
    logic [7:0] rd;
    int lat;
    int order [$];
    bit got_a, got_b, dir_seen;
    logic [7:0] a_rd;

    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[0] = 8'hA9;

    // T1: reset state, memory off so the controller's release is visible
    repeat (2) @(posedge clk);
    #1;
    chk("t1_le", 32'(mem_le), 32'd1);
    chk("t1_bus_z", 32'(mem_datos === 8'hzz), 32'd1);
    chk("t1_acks", 32'({a_ack, b_ack}), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_dir", 32'(mem_dir), 32'd0);
    chk("t1_owner", 32'(owner), 32'd0);
    chk("t1_rdata", 32'({a_rdata, b_rdata}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    mem_en = 1'b1;
    mon_on = 1'b1;
    @(negedge clk);

    // T2: A write then read back
    txn("t2_wr", 0, 1, 16'h0010, 8'h3C, rd, lat);
    chk("t2_wr_lat", 32'(lat), 32'd3);
    chk("t2_mem", 32'(mem[16'h0010]), 32'h3C);
    txn("t2_rd", 0, 0, 16'h0010, 8'h00, rd, lat);
    chk("t2_rd_lat", 32'(lat), 32'd3);
    chk("t2_rdata", 32'(rd), 32'h3C);

    // T3: both requesters held, reads, grants must alternate starting with A
    apply_reset();
    a_we = 0; a_dir = 16'h0100; b_we = 0; b_dir = 16'h0203;
    a_req = 1; b_req = 1;
    for (int c = 0; c < 60 && order.size() < 4; c++) begin
      @(posedge clk); #1;
      if (a_ack && b_ack) chk("t3_dual_ack", 32'd1, 32'd0);
      if (a_ack) begin
        order.push_back(0);
        chk("t3_owner_a", 32'(owner), 32'd0);
        chk("t3_a_rdata", 32'(a_rdata), 32'h5A);
      end
      if (b_ack) begin
        order.push_back(1);
        chk("t3_owner_b", 32'(owner), 32'd1);
        chk("t3_b_rdata", 32'(b_rdata), 32'h59);
      end
    end
    a_req = 0; b_req = 0;
    chk("t3_count", 32'(order.size()), 32'd4);
    for (int k = 0; k < order.size(); k++) chk("t3_order", 32'(order[k]), 32'(k % 2));
    repeat (6) @(posedge clk);

    // T4: B writes top address while A reads the program byte at 0
    apply_reset();
    a_we = 0; a_dir = 16'h0000;
    b_we = 1; b_dir = 16'hFFFF; b_wdata = 8'hAA;
    a_req = 1; b_req = 1;
    got_a = 0; got_b = 0; dir_seen = 0; a_rd = '0;
    for (int c = 0; c < 40 && !(got_a && got_b); c++) begin
      @(posedge clk); #1;
      if (busy && owner && !dir_seen) begin
        dir_seen = 1;
        chk("t4_dir_ffff", 32'(mem_dir), 32'hFFFF);
      end
      if (a_ack) begin got_a = 1; a_rd = a_rdata; a_req = 0; end
      if (b_ack) begin got_b = 1; b_req = 0; end
    end
    a_req = 0; b_req = 0;
    chk("t4_both_done", 32'({got_a, got_b}), 32'h3);
    chk("t4_a_prog_byte", 32'(a_rd), 32'hA9);
    chk("t4_mem_ffff", 32'(mem[16'hFFFF]), 32'hAA);
    @(posedge clk); #1;
    txn("t4_rb", 1, 0, 16'hFFFF, 8'h00, rd, lat);
    chk("t4_readback", 32'(rd), 32'hAA);

    // T5: reset during the write strobe
    mem_en = 0;
    b_req = 1; b_we = 1; b_dir = 16'h0020; b_wdata = 8'h55;
    lat = 0;
    while (mem_le !== 1'b0 && lat < 10) begin @(posedge clk); #1; lat++; end
    chk("t5_le_low", 32'(mem_le), 32'd0);
    chk("t5_bus_drv", 32'(mem_datos), 32'h55);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_le_high", 32'(mem_le), 32'd1);
    chk("t5_bus_z", 32'(mem_datos === 8'hzz), 32'd1);
    chk("t5_no_ack", 32'({a_ack, b_ack}), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    b_req = 0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    mem_en = 1;
    chk("t5_committed", 32'(mem[16'h0020]), 32'h55);
    @(negedge clk);
    txn("t5_rd", 0, 0, 16'h0020, 8'h00, rd, lat);
    chk("t5_rd_lat", 32'(lat), 32'd3);
    chk("t5_rdata", 32'(rd), 32'h55);

    mon_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
